// File: rtl/mau_pkg.sv
// Shared constants, funct3 codes and state encoding for the memory access unit.
package mau_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BE_W     = 4;
  localparam int unsigned FUNCT3_W = 3;

  // Load/store size codes as carried in the instruction funct3 field
  localparam logic [FUNCT3_W-1:0] F3_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] F3_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] F3_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] F3_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] F3_HU = 3'b101;

  localparam logic [1:0] STATE_IDLE = 2'd0;
  localparam logic [1:0] STATE_REQ  = 2'd1;
  localparam logic [1:0] STATE_DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = STATE_IDLE,
    ST_REQ  = STATE_REQ,
    ST_DONE = STATE_DONE
  } state_e;

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering: store enables/data, alignment check and load extraction.
module mau_lane_align
  import mau_pkg::*;
(
  input  logic [1:0]          addr_lo_i,
  input  logic [FUNCT3_W-1:0] funct3_i,
  input  logic                we_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [BE_W-1:0]     be_o,
  output logic [DATA_W-1:0]   wdata_o,
  output logic                misalign_o,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        is_signed;

  // Size comes from funct3[1:0]; funct3[2] selects zero extension on loads
  always_comb begin
    be_o       = 4'b1111;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    rdata_o    = rdata_i;
    is_signed  = ~funct3_i[2];
    half_sel   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase

    case (funct3_i[1:0])
      2'b00: begin
        if (we_i) begin
          be_o    = 4'b0001 << addr_lo_i;
          wdata_o = {4{wdata_i[7:0]}};
        end
        rdata_o = {{24{is_signed & byte_sel[7]}}, byte_sel};
      end
      2'b01: begin
        misalign_o = addr_lo_i[0];
        if (we_i) begin
          be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
          wdata_o = {2{wdata_i[15:0]}};
        end
        rdata_o = {{16{is_signed & half_sel[15]}}, half_sel};
      end
      default: begin
        misalign_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Bridges multicycle FSM memory strobes to a req/ack bus; holds IR and MDR.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                adr_src_i,
  input  logic [ADDR_W-1:0]   pc_i,
  input  logic [ADDR_W-1:0]   result_i,
  input  logic                mem_rd_i,
  input  logic                mem_wr_i,
  input  logic                ir_write_i,
  input  logic [FUNCT3_W-1:0] funct3_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                err_clr_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   instr_o,
  output logic [DATA_W-1:0]   mdr_o,
  output logic                misalign_o,
  output logic                timeout_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [BE_W-1:0]     bus_be_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_ack_i,
  input  logic [DATA_W-1:0]   bus_rdata_i
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 2);

  state_e              state_q, state_d;
  logic [1:0]          addr_lo_q, addr_lo_d;
  logic [FUNCT3_W-1:0] f3_q, f3_d;
  logic                we_q, we_d;
  logic                irw_q, irw_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [DATA_W-1:0]   mdr_q, mdr_d;
  logic                misalign_q, misalign_d;
  logic                timeout_q, timeout_d;
  logic                done_q, done_d;
  logic                req_q, req_d;
  logic                bus_we_q, bus_we_d;
  logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
  logic [BE_W-1:0]     bus_be_q, bus_be_d;
  logic [DATA_W-1:0]   bus_wdata_q, bus_wdata_d;
  logic                leave_req;

  logic [ADDR_W-1:0]   addr_c;
  logic [FUNCT3_W-1:0] f3_c;
  logic                access_c;
  logic                in_idle_c;
  logic [1:0]          la_addr_lo;
  logic [FUNCT3_W-1:0] la_f3;
  logic                la_we;
  logic [BE_W-1:0]     la_be;
  logic [DATA_W-1:0]   la_wdata;
  logic                la_misalign;
  logic [DATA_W-1:0]   la_rdata;

  // Fetches are always full words regardless of funct3
  assign addr_c    = adr_src_i ? result_i : pc_i;
  assign f3_c      = adr_src_i ? funct3_i : F3_W;
  assign access_c  = mem_rd_i | mem_wr_i;
  assign in_idle_c = (state_q == ST_IDLE);

  // Lane logic sees the live request in IDLE, the captured one afterwards
  assign la_addr_lo = in_idle_c ? addr_c[1:0] : addr_lo_q;
  assign la_f3      = in_idle_c ? f3_c : f3_q;
  assign la_we      = in_idle_c ? mem_wr_i : we_q;

  mau_lane_align u_lane_align (
    .addr_lo_i  (la_addr_lo),
    .funct3_i   (la_f3),
    .we_i       (la_we),
    .wdata_i    (wdata_i),
    .rdata_i    (bus_rdata_i),
    .be_o       (la_be),
    .wdata_o    (la_wdata),
    .misalign_o (la_misalign),
    .rdata_o    (la_rdata)
  );

  // Next-state, capture and bus-control logic
  always_comb begin
    state_d     = state_q;
    addr_lo_d   = addr_lo_q;
    f3_d        = f3_q;
    we_d        = we_q;
    irw_d       = irw_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    mdr_d       = mdr_q;
    misalign_d  = misalign_q;
    timeout_d   = timeout_q;
    done_d      = 1'b0;
    req_d       = req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    busy_o      = 1'b0;
    leave_req   = 1'b0;

    // Clear first so an error setting this cycle wins
    if (err_clr_i) begin
      misalign_d = 1'b0;
      timeout_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        busy_o = access_c;
        if (access_c) begin
          addr_lo_d = addr_c[1:0];
          f3_d      = f3_c;
          we_d      = mem_wr_i;
          irw_d     = ir_write_i;
          cnt_d     = '0;
          if (la_misalign) begin
            misalign_d = 1'b1;
            done_d     = 1'b1;
            state_d    = ST_DONE;
            if (!mem_wr_i) begin
              if (ir_write_i) instr_d = '0;
              else            mdr_d   = '0;
            end
          end else begin
            state_d     = ST_REQ;
            req_d       = 1'b1;
            bus_we_d    = mem_wr_i;
            bus_addr_d  = {addr_c[ADDR_W-1:2], 2'b00};
            bus_be_d    = la_be;
            bus_wdata_d = mem_wr_i ? la_wdata : '0;
          end
        end
      end
      ST_REQ: begin
        busy_o = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (bus_ack_i) begin
          leave_req = 1'b1;
          if (!we_q) begin
            if (irw_q) instr_d = bus_rdata_i;
            else       mdr_d   = la_rdata;
          end
        end else if ((TIMEOUT_CYC != 32'd0) &&
                     (cnt_q == CNT_W'(TIMEOUT_CYC - 32'd1))) begin
          leave_req = 1'b1;
          timeout_d = 1'b1;
          if (!we_q) begin
            if (irw_q) instr_d = '0;
            else       mdr_d   = '0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (leave_req) begin
      state_d     = ST_DONE;
      done_d      = 1'b1;
      req_d       = 1'b0;
      bus_we_d    = 1'b0;
      bus_addr_d  = '0;
      bus_be_d    = '0;
      bus_wdata_d = '0;
    end
  end

  // State and output registers; reset drops the bus request immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_lo_q   <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      irw_q       <= 1'b0;
      cnt_q       <= '0;
      instr_q     <= '0;
      mdr_q       <= '0;
      misalign_q  <= 1'b0;
      timeout_q   <= 1'b0;
      done_q      <= 1'b0;
      req_q       <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_be_q    <= '0;
      bus_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_lo_q   <= addr_lo_d;
      f3_q        <= f3_d;
      we_q        <= we_d;
      irw_q       <= irw_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      mdr_q       <= mdr_d;
      misalign_q  <= misalign_d;
      timeout_q   <= timeout_d;
      done_q      <= done_d;
      req_q       <= req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_be_q    <= bus_be_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  assign done_o      = done_q;
  assign instr_o     = instr_q;
  assign mdr_o       = mdr_q;
  assign misalign_o  = misalign_q;
  assign timeout_o   = timeout_q;
  assign bus_req_o   = req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_be_o    = bus_be_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table, corner sequences, random vs model.
module tb_mem_access_unit;

  localparam int unsigned TO = 4;

  logic        clk;
  logic        rst;
  logic        adr_src_i;
  logic [31:0] pc_i;
  logic [31:0] result_i;
  logic        mem_rd_i;
  logic        mem_wr_i;
  logic        ir_write_i;
  logic [2:0]  funct3_i;
  logic [31:0] wdata_i;
  logic        err_clr_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] instr_o;
  logic [31:0] mdr_o;
  logic        misalign_o;
  logic        timeout_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;

  mem_access_unit #(.TIMEOUT_CYC(TO), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .adr_src_i   (adr_src_i),
    .pc_i        (pc_i),
    .result_i    (result_i),
    .mem_rd_i    (mem_rd_i),
    .mem_wr_i    (mem_wr_i),
    .ir_write_i  (ir_write_i),
    .funct3_i    (funct3_i),
    .wdata_i     (wdata_i),
    .err_clr_i   (err_clr_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .instr_o     (instr_o),
    .mdr_o       (mdr_o),
    .misalign_o  (misalign_o),
    .timeout_o   (timeout_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_be_o    (bus_be_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_ack_i   (bus_ack_i),
    .bus_rdata_i (bus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        adr_src;
    logic [31:0] pc;
    logic [31:0] result;
    logic        rd;
    logic        wr;
    logic        irw;
    logic [2:0]  f3;
    logic [31:0] wdata;
    int          wait_n;
    logic        no_ack;
    logic [31:0] rdata;
    logic        clr;
  } acc_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          req_cycles;
    logic [31:0] instr;
    logic [31:0] mdr;
    logic        mis;
    logic        to;
  } exp_t;

  typedef struct {
    acc_t a;
    exp_t e;
  } vec_t;

  int    n_checks = 0;
  int    n_pass   = 0;
  string cur_tag  = "init";

  logic [31:0] m_instr = 0;
  logic [31:0] m_mdr   = 0;
  logic        m_mis   = 0;
  logic        m_to    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v)
      $display("FAIL %s [%s]: got %h expected %h", name, cur_tag, act, exp_v);
    else
      n_pass++;
  endtask

  function automatic acc_t mk_acc(input logic adr_src, input logic [31:0] pc,
                                  input logic [31:0] result, input logic rd, input logic wr,
                                  input logic irw, input logic [2:0] f3, input logic [31:0] wdata,
                                  input int wait_n, input logic no_ack,
                                  input logic [31:0] rdata, input logic clr);
    acc_t a;
    a.adr_src = adr_src; a.pc = pc; a.result = result; a.rd = rd; a.wr = wr;
    a.irw = irw; a.f3 = f3; a.wdata = wdata; a.wait_n = wait_n;
    a.no_ack = no_ack; a.rdata = rdata; a.clr = clr;
    return a;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] addr, input logic [3:0] be,
                                  input logic [31:0] wdata, input logic we, input int req,
                                  input logic [31:0] instr, input logic [31:0] mdr,
                                  input logic mis, input logic to);
    exp_t e;
    e.addr = addr; e.be = be; e.wdata = wdata; e.we = we; e.req_cycles = req;
    e.instr = instr; e.mdr = mdr; e.mis = mis; e.to = to;
    return e;
  endfunction

  // Reference model: size/offset arithmetic straight from the access rules
  function automatic exp_t model(input acc_t a);
    exp_t        e;
    logic [31:0] addr;
    logic [31:0] v;
    logic [31:0] mask;
    int          size;
    int          off;
    if (a.clr) begin m_mis = 0; m_to = 0; end
    addr = a.adr_src ? a.result : a.pc;
    if (!a.adr_src)            size = 4;
    else if (a.f3[1:0] == 2'b00) size = 1;
    else if (a.f3[1:0] == 2'b01) size = 2;
    else                       size = 4;
    off    = int'(addr % 32'd4);
    e.addr = addr - 32'(off);
    e.we   = a.wr;
    e.be   = a.wr ? 4'(((1 << size) - 1) << off) : 4'hF;
    if (size == 1)      e.wdata = {4{a.wdata[7:0]}};
    else if (size == 2) e.wdata = {2{a.wdata[15:0]}};
    else                e.wdata = a.wdata;
    v    = a.rdata >> (8 * off);
    mask = (size == 4) ? 32'hFFFF_FFFF : 32'((64'd1 << (8 * size)) - 64'd1);
    v    = v & mask;
    if (a.adr_src && !a.f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
    if ((addr % 32'(size)) != 0) begin
      e.req_cycles = 0;
      m_mis = 1;
      v = 0;
    end else if (a.no_ack) begin
      e.req_cycles = int'(TO);
      m_to = 1;
      v = 0;
    end else begin
      e.req_cycles = a.wait_n + 1;
    end
    if (!a.wr) begin
      if (a.irw) m_instr = v;
      else       m_mdr   = v;
    end
    e.instr = m_instr; e.mdr = m_mdr; e.mis = m_mis; e.to = m_to;
    return e;
  endfunction

  // Drive one access, play the bus slave, and check the whole transaction
  task automatic run_access(input acc_t a, input exp_t e);
    int          req_cnt;
    int          busy_cnt;
    int          cycles;
    logic        finished;
    logic        stable;
    logic        ack;
    logic [31:0] f_addr;
    logic [3:0]  f_be;
    logic        f_we;
    logic [31:0] f_wdata;
    req_cnt = 0; busy_cnt = 0; cycles = 0; finished = 0; stable = 1;
    f_addr = 0; f_be = 0; f_we = 0; f_wdata = 0;
    if (a.clr) begin
      @(posedge clk); #1;
      err_clr_i = 1'b1;
      @(posedge clk); #1;
      err_clr_i = 1'b0;
      @(negedge clk);
      chk("err_clr", 32'({misalign_o, timeout_o}), 32'h0);
    end
    @(posedge clk); #1;
    adr_src_i = a.adr_src; pc_i = a.pc; result_i = a.result;
    mem_rd_i = a.rd; mem_wr_i = a.wr; ir_write_i = a.irw;
    funct3_i = a.f3; wdata_i = a.wdata; bus_ack_i = 1'b0;
    @(negedge clk);
    chk("busy_idle", 32'(busy_o), 32'h1);
    if (busy_o) busy_cnt++;
    for (int c = 0; c < 16 && !finished; c++) begin
      @(posedge clk); #1;
      bus_ack_i = 1'b0;
      if (bus_req_o) begin
        ack = !a.no_ack && (req_cnt == a.wait_n);
        bus_ack_i   = ack;
        bus_rdata_i = ack ? a.rdata : $urandom;
      end
      @(negedge clk);
      cycles++;
      if (bus_req_o) begin
        if (req_cnt == 0) begin
          f_addr = bus_addr_o; f_be = bus_be_o; f_we = bus_we_o; f_wdata = bus_wdata_o;
        end else if (bus_addr_o !== f_addr || bus_be_o !== f_be ||
                     bus_we_o !== f_we || bus_wdata_o !== f_wdata) begin
          stable = 0;
        end
        req_cnt++;
      end
      if (busy_o) busy_cnt++;
      if (done_o) finished = 1;
    end
    chk("done_seen", 32'(finished), 32'h1);
    chk("req_cycles", 32'(req_cnt), 32'(e.req_cycles));
    chk("latency", 32'(cycles), 32'(e.req_cycles + 1));
    chk("busy_cycles", 32'(busy_cnt), 32'(e.req_cycles + 1));
    if (e.req_cycles > 0) begin
      chk("bus_addr", f_addr, e.addr);
      chk("bus_be", 32'(f_be), 32'(e.be));
      chk("bus_we", 32'(f_we), 32'(e.we));
      if (e.we) chk("bus_wdata", f_wdata, e.wdata);
      if (req_cnt > 1) chk("bus_stable", 32'(stable), 32'h1);
    end
    @(posedge clk); #1;
    mem_rd_i = 1'b0; mem_wr_i = 1'b0; ir_write_i = 1'b0; bus_ack_i = 1'b0;
    @(negedge clk);
    chk("done_pulse", 32'(done_o), 32'h0);
    chk("busy_after", 32'(busy_o), 32'h0);
    chk("req_after", 32'(bus_req_o), 32'h0);
    chk("instr", instr_o, e.instr);
    chk("mdr", mdr_o, e.mdr);
    chk("misalign", 32'(misalign_o), 32'(e.mis));
    chk("timeout", 32'(timeout_o), 32'(e.to));
  endtask

  vec_t tbl[13];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    acc_t a;
    exp_t e;
    logic [31:0] r;
    int kind;

    rst = 1'b0; adr_src_i = 0; pc_i = 0; result_i = 0; mem_rd_i = 0; mem_wr_i = 0;
    ir_write_i = 0; funct3_i = 0; wdata_i = 0; err_clr_i = 0; bus_ack_i = 0; bus_rdata_i = 0;

    tbl[0].a  = mk_acc(0, 32'h100, 32'h0,   1, 0, 1, 3'b010, 32'h0, 2, 0, 32'h00A0_0093, 0);
    tbl[0].e  = mk_exp(32'h100, 4'hF, 32'h0, 0, 3, 32'h00A0_0093, 32'h0, 0, 0);
    tbl[1].a  = mk_acc(1, 32'h0, 32'h203,   1, 0, 0, 3'b000, 32'h0, 0, 0, 32'h80FF_1234, 0);
    tbl[1].e  = mk_exp(32'h200, 4'hF, 32'h0, 0, 1, 32'h00A0_0093, 32'hFFFF_FF80, 0, 0);
    tbl[2].a  = mk_acc(1, 32'h0, 32'h203,   1, 0, 0, 3'b100, 32'h0, 1, 0, 32'h80FF_1234, 0);
    tbl[2].e  = mk_exp(32'h200, 4'hF, 32'h0, 0, 2, 32'h00A0_0093, 32'h0000_0080, 0, 0);
    tbl[3].a  = mk_acc(1, 32'h0, 32'h202,   1, 0, 0, 3'b001, 32'h0, 0, 0, 32'h80FF_1234, 0);
    tbl[3].e  = mk_exp(32'h200, 4'hF, 32'h0, 0, 1, 32'h00A0_0093, 32'hFFFF_80FF, 0, 0);
    tbl[4].a  = mk_acc(1, 32'h0, 32'h201,   0, 1, 0, 3'b000, 32'h0000_00AB, 1, 0, 32'h0, 0);
    tbl[4].e  = mk_exp(32'h200, 4'b0010, 32'hABAB_ABAB, 1, 2, 32'h00A0_0093, 32'hFFFF_80FF, 0, 0);
    tbl[5].a  = mk_acc(1, 32'h0, 32'h202,   0, 1, 0, 3'b001, 32'h0000_1234, 0, 0, 32'h0, 0);
    tbl[5].e  = mk_exp(32'h200, 4'b1100, 32'h1234_1234, 1, 1, 32'h00A0_0093, 32'hFFFF_80FF, 0, 0);
    tbl[6].a  = mk_acc(1, 32'h0, 32'h102,   0, 1, 0, 3'b010, 32'hCAFE_BABE, 0, 0, 32'h0, 0);
    tbl[6].e  = mk_exp(32'h0, 4'h0, 32'h0, 0, 0, 32'h00A0_0093, 32'hFFFF_80FF, 1, 0);
    tbl[7].a  = mk_acc(1, 32'h0, 32'h300,   1, 0, 0, 3'b010, 32'h0, 0, 1, 32'h1234_5678, 1);
    tbl[7].e  = mk_exp(32'h300, 4'hF, 32'h0, 0, 4, 32'h00A0_0093, 32'h0, 0, 1);
    tbl[8].a  = mk_acc(1, 32'h0, 32'h400,   1, 1, 0, 3'b010, 32'hDEAD_BEEF, 0, 0, 32'h0, 1);
    tbl[8].e  = mk_exp(32'h400, 4'hF, 32'hDEAD_BEEF, 1, 1, 32'h00A0_0093, 32'h0, 0, 0);
    tbl[9].a  = mk_acc(1, 32'h0, 32'h404,   1, 0, 0, 3'b010, 32'h0, 3, 0, 32'h1122_3344, 0);
    tbl[9].e  = mk_exp(32'h404, 4'hF, 32'h0, 0, 4, 32'h00A0_0093, 32'h1122_3344, 0, 0);
    tbl[10].a = mk_acc(1, 32'h0, 32'h301,   1, 0, 0, 3'b101, 32'h0, 0, 0, 32'hFFFF_FFFF, 0);
    tbl[10].e = mk_exp(32'h0, 4'h0, 32'h0, 0, 0, 32'h00A0_0093, 32'h0, 1, 0);
    tbl[11].a = mk_acc(0, 32'h102, 32'h0,   1, 0, 1, 3'b000, 32'h0, 0, 0, 32'hFFFF_FFFF, 1);
    tbl[11].e = mk_exp(32'h0, 4'h0, 32'h0, 0, 0, 32'h0, 32'h0, 1, 0);
    tbl[12].a = mk_acc(0, 32'h104, 32'h0,   1, 0, 1, 3'b000, 32'h0, 0, 0, 32'hCAFE_F00D, 0);
    tbl[12].e = mk_exp(32'h104, 4'hF, 32'h0, 0, 1, 32'hCAFE_F00D, 32'h0, 1, 0);

    // Reset state
    #2;
    cur_tag = "reset";
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_mdr", mdr_o, 32'h0);
    chk("rst_flags", 32'({misalign_o, timeout_o}), 32'h0);
    chk("rst_bus_req", 32'(bus_req_o), 32'h0);
    chk("rst_bus", 32'({bus_we_o, bus_be_o}), 32'h0);
    chk("rst_bus_addr", bus_addr_o, 32'h0);
    chk("rst_bus_wdata", bus_wdata_o, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Directed table
    for (int i = 0; i < 13; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_access(tbl[i].a, tbl[i].e);
      m_instr = tbl[i].e.instr; m_mdr = tbl[i].e.mdr;
      m_mis = tbl[i].e.mis; m_to = tbl[i].e.to;
    end

    // Error set and clear in the same cycle: set wins
    cur_tag = "set_wins";
    @(posedge clk); #1;
    adr_src_i = 1; result_i = 32'h3; mem_wr_i = 1; funct3_i = 3'b010; err_clr_i = 1;
    @(posedge clk); #1;
    err_clr_i = 0;
    @(negedge clk);
    chk("set_wins_flag", 32'(misalign_o), 32'h1);
    chk("set_wins_done", 32'(done_o), 32'h1);
    chk("set_wins_noreq", 32'(bus_req_o), 32'h0);
    @(posedge clk); #1;
    mem_wr_i = 0;
    m_mis = 1;

    // Load MDR with something nonzero, then reset in the middle of a fetch
    cur_tag = "pre_reset";
    a = mk_acc(1, 32'h0, 32'h500, 1, 0, 0, 3'b010, 32'h0, 0, 0, 32'h55AA_55AA, 0);
    e = model(a);
    run_access(a, e);
    cur_tag = "reset_mid_req";
    @(posedge clk); #1;
    adr_src_i = 0; pc_i = 32'h200; mem_rd_i = 1; ir_write_i = 1; bus_ack_i = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("req_before_reset", 32'(bus_req_o), 32'h1);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_req_drop", 32'(bus_req_o), 32'h0);
    chk("reset_instr", instr_o, 32'h0);
    chk("reset_mdr", mdr_o, 32'h0);
    chk("reset_flags", 32'({misalign_o, timeout_o, done_o}), 32'h0);
    mem_rd_i = 0; ir_write_i = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", 32'({busy_o, bus_req_o}), 32'h0);
    m_instr = 0; m_mdr = 0; m_mis = 0; m_to = 0;

    // Randomized accesses against the model
    for (int n = 0; n < 150; n++) begin
      cur_tag = $sformatf("rand%0d", n);
      r = $urandom;
      if ($urandom_range(0, 1) == 0) r[1:0] = 2'b00;
      a.adr_src = ($urandom_range(0, 3) != 0);
      a.pc = r; a.result = r;
      if (a.adr_src) begin
        kind = int'($urandom_range(0, 2));
        a.rd = (kind != 1); a.wr = (kind != 0); a.irw = 0;
      end else begin
        a.rd = 1; a.wr = 0; a.irw = 1;
      end
      a.f3     = 3'($urandom_range(0, 7));
      a.wdata  = $urandom;
      a.rdata  = $urandom;
      a.wait_n = int'($urandom_range(0, 3));
      a.no_ack = ($urandom_range(0, 9) == 0);
      a.clr    = ($urandom_range(0, 7) == 0);
      e = model(a);
      run_access(a, e);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits between the multicycle RISC-V control FSM/datapath and the unified instruction/data memory bus.
- Turns the FSM's per-state memory strobes into a req/ack bus transaction, with byte-lane alignment for stores and sign/zero extension for loads.
- Holds the instruction register and memory data register, and stalls the FSM via busy_o until each access completes.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles in REQ without bus_ack_i before abort; 0 disables the timeout.
- ADDR_W, 32: byte address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- adr_src_i  in  1  0: address = pc_i (fetch); 1: address = result_i (data)
- pc_i  in  ADDR_W  current PC
- result_i  in  ADDR_W  computed data address
- mem_rd_i  in  1  read request, level, from FSM state
- mem_wr_i  in  1  write request (MemWrite)
- ir_write_i  in  1  completed read loads instr_o
- funct3_i  in  3  load/store size code
- wdata_i  in  32  store data (rs2 register)
- err_clr_i  in  1  synchronous clear of sticky error flags
- busy_o  out  1  FSM must hold its state while high
- done_o  out  1  one-cycle completion pulse
- instr_o  out  32  instruction register
- mdr_o  out  32  extended load data register
- misalign_o  out  1  sticky misaligned-access flag
- timeout_o  out  1  sticky bus-timeout flag
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write enable
- bus_addr_o  out  ADDR_W  word-aligned address, bits [1:0] = 0
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-aligned store data
- bus_ack_i  in  1  bus completion, single cycle
- bus_rdata_i  in  32  read data, valid with bus_ack_i

Behaviour:
- Reset values: state IDLE; all outputs 0; instr_o = 0; mdr_o = 0; bus_req_o drops asynchronously on reset, including mid-transaction.
- States: IDLE, REQ, DONE.
- IDLE:
  - If mem_rd_i|mem_wr_i: capture address, we, funct3, wdata, ir_write; busy_o = 1 combinationally that same cycle.
  - If the access is misaligned: set misalign_o, go to DONE, issue no bus request.
  - Otherwise go to REQ.
  - mem_wr_i has priority when both requests are high.
- REQ:
  - bus_req_o = 1; address, we, be and wdata held stable; busy_o = 1.
  - On bus_ack_i: if read, latch data into mdr_o, or into instr_o when captured ir_write = 1; go to DONE.
  - Timeout counter increments each REQ cycle. On reaching TIMEOUT_CYC without ack: drop bus_req_o, set timeout_o, load the destination register with 0, go to DONE.
- DONE: done_o = 1, busy_o = 0, next state IDLE. Requests seen during DONE are ignored (they belong to the finished FSM state).
- Latency: minimum 3 cycles (IDLE, REQ with immediate ack, DONE); N extra cycles for N wait states.
- Fetch (adr_src_i = 0): always a word access, funct3 ignored, misaligned if pc[1:0] != 0.
- Data alignment by funct3:
  - 000 LB/SB and 100 LBU: any address.
  - 001 LH/SH and 101 LHU: addr[0] = 0.
  - 010 LW/SW: addr[1:0] = 0.
  - 011/110/111 treated as word.
- Store lanes:
  - SB: be = 0001 << addr[1:0]; wdata = byte replicated to all 4 lanes.
  - SH: be = 0011 << {addr[1],0}; wdata = halfword replicated.
  - SW: be = 1111.
  - Reads always drive be = 1111.
- Load extract: select byte or halfword by addr; sign-extend for 000/001, zero-extend for 100/101.
- Misaligned read: destination register loaded with 0. Misaligned write: no bus write occurs.
- err_clr_i clears both sticky flags. If a new error sets in the same cycle, set wins.

Decomposition:
- Package mau_pkg: funct3 codes (F3_B, F3_H, F3_W, F3_BU, F3_HU), state encoding localparams, width constants.
- Sub-module mau_lane_align: purely combinational. Computes be, store-lane wdata, misalign flag and load extraction/extension from addr[1:0], funct3, we.

Test Plan:
- Fetch at pc = 0x100, ir_write = 1, ack after 2 wait cycles, rdata = 0x00A00093 → bus_addr = 0x100, be = 1111, busy for 4 cycles, done pulse, instr_o = 0x00A00093.
- LB at 0x203, rdata = 0x80FF_1234 → mdr_o = 0xFFFF_FF80; LBU same → 0x0000_0080; LH at 0x202 → 0xFFFF_80FF.
- SB at 0x201, wdata = 0x0000_00AB → be = 0010, bus_wdata = 0xABAB_ABAB, we = 1; SH at 0x202, wdata = 0x1234 → be = 1100.
- SW at 0x102 → no bus_req, misalign_o = 1, done after 2 cycles; err_clr_i → misalign_o = 0.
- TIMEOUT_CYC = 4 with ack never asserted → bus_req high exactly 4 cycles, timeout_o = 1, mdr_o = 0, done pulse.
- Assert rst low during REQ → bus_req_o = 0 immediately, state IDLE, instr_o = mdr_o = 0; mem_rd_i and mem_wr_i both high → write issued.
